dmi_req_handshake_ctrl: RTL and testbench



---
 rtl/dmi_pkg.sv | 21 ++
 rtl/dmi_timeout_counter.sv | 46 ++++
 rtl/dmi_req_handshake_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmi_req_handshake_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// Shared types and defaults for the core-side DMI request handshake.
package dmi_pkg;

    localparam int unsigned DMI_ADDR_W_DEFAULT  = 7;
    localparam int unsigned DMI_DATA_W_DEFAULT  = 32;
    localparam int unsigned DMI_TIMEOUT_DEFAULT = 255;

    // Handshake FSM states; encoding is fixed so debug views stay stable.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StWaitRsp = 2'd2,
        StAck     = 2'd3
    } dmi_state_e;

    // Width needed to hold TIMEOUT_CYCLES itself; never narrower than 1 bit.
    function automatic int unsigned dmi_cnt_width(input int unsigned timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/dmi_timeout_counter.sv
// Saturating response-timeout counter. expired_o goes high once the count
// reaches TIMEOUT_CYCLES; a zero TIMEOUT_CYCLES disables expiry entirely.
module dmi_timeout_counter
    import dmi_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMI_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned     CntW   = dmi_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: clear wins over enable; stop at CntMax so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
        assign expired_o = 1'b0;
    end else begin : g_timeout
        assign expired_o = (cnt_q == CntMax);
    end

endmodule

// File: rtl/dmi_req_handshake_ctrl.sv
// Core-domain side of the DMI 4-phase req/ack handshake. Captures the DMI
// request, issues it on the core debug bus, waits for a response or timeout
// and returns a level ack with the read data and error flag. All outputs
// come straight from flops.
module dmi_req_handshake_ctrl
    import dmi_pkg::*;
#(
    parameter int unsigned ADDR_W         = DMI_ADDR_W_DEFAULT,
    parameter int unsigned DATA_W         = DMI_DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = DMI_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_sync,
    input  logic [ADDR_W-1:0] dmi_addr_in,
    input  logic [DATA_W-1:0] dmi_wdata_in,
    input  logic              dmi_wr_in,
    output logic              core_req_valid,
    input  logic              core_req_ready,
    output logic [ADDR_W-1:0] core_req_addr,
    output logic [DATA_W-1:0] core_req_wdata,
    output logic              core_req_wr,
    input  logic              core_rsp_valid,
    input  logic [DATA_W-1:0] core_rsp_rdata,
    input  logic              core_rsp_err,
    output logic              ack_out,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err_out
);

    dmi_state_e        state_q,  state_d;
    logic              valid_q,  valid_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic              wr_q,     wr_d;
    logic              ack_q,    ack_d;
    logic [DATA_W-1:0] rdata_q,  rdata_d;
    logic              err_q,    err_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    dmi_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (cnt_expired)
    );

    // Next-state and registered-output logic for the handshake FSM.
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        ack_d     = ack_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_sync) begin
                    addr_d  = dmi_addr_in;
                    wdata_d = dmi_wdata_in;
                    wr_d    = dmi_wr_in;
                    valid_d = 1'b1;
                    state_d = StReq;
                end
            end
            // req_sync is deliberately not looked at here: a request that has
            // been captured always runs to completion.
            StReq: begin
                if (core_req_ready) begin
                    valid_d   = 1'b0;
                    cnt_clear = 1'b1;
                    state_d   = StWaitRsp;
                end
            end
            StWaitRsp: begin
                cnt_en = 1'b1;
                // A response on the expiry cycle still counts as a response.
                if (core_rsp_valid) begin
                    rdata_d = core_rsp_rdata;
                    err_d   = core_rsp_err;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else if (cnt_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            // If req_sync already fell early, this leaves after one cycle and
            // ack_out becomes a single-cycle pulse.
            StAck: begin
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign core_req_valid = valid_q;
    assign core_req_addr  = addr_q;
    assign core_req_wdata = wdata_q;
    assign core_req_wr    = wr_q;
    assign ack_out        = ack_q;
    assign rdata_out      = rdata_q;
    assign err_out        = err_q;

endmodule

// File: tb/tb_dmi_req_handshake_ctrl.sv
// Self-checking bench for dmi_req_handshake_ctrl. Expected behaviour is
// computed per transaction from its timing parameters (ready delay, response
// delay, timeout, release time) rather than by tracking the DUT state.
module tb_dmi_req_handshake_ctrl;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_sync;
    logic [AW-1:0] dmi_addr_in;
    logic [DW-1:0] dmi_wdata_in;
    logic          dmi_wr_in;
    logic          core_req_valid;
    logic          core_req_ready;
    logic [AW-1:0] core_req_addr;
    logic [DW-1:0] core_req_wdata;
    logic          core_req_wr;
    logic          core_rsp_valid;
    logic [DW-1:0] core_rsp_rdata;
    logic          core_rsp_err;
    logic          ack_out;
    logic [DW-1:0] rdata_out;
    logic          err_out;

    int checks   = 0;
    int failures = 0;

    dmi_req_handshake_ctrl #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_sync       (req_sync),
        .dmi_addr_in    (dmi_addr_in),
        .dmi_wdata_in   (dmi_wdata_in),
        .dmi_wr_in      (dmi_wr_in),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_addr  (core_req_addr),
        .core_req_wdata (core_req_wdata),
        .core_req_wr    (core_req_wr),
        .core_rsp_valid (core_rsp_valid),
        .core_rsp_rdata (core_rsp_rdata),
        .core_rsp_err   (core_rsp_err),
        .ack_out        (ack_out),
        .rdata_out      (rdata_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    // One transaction. c counts clock edges from the one that first samples
    // req_sync=1; outputs are observed 1 ns after edge c.
    //   request valid after edges 0..rdly, ready sampled at edge rdly+1
    //   wait cycle k lasts from edge rdly+1+k; response sampled at edge rdly+k+2
    //   expiry happens on wait cycle T; a response on that cycle still wins
    task automatic run_txn(input string name, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic wr, input int rdly,
                           input int rspd, input logic [DW-1:0] rdata, input logic rerr,
                           input bit early, input int hold);
        bit            resp_wins;
        int            ack_c, drop_c, low_c, rsp_c;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        bit            exp_valid, exp_ack;
        string         tag;

        resp_wins = (rspd >= 0) && (rspd <= T);
        ack_c     = rdly + (resp_wins ? rspd : T) + 2;
        drop_c    = early ? 1 : ack_c + hold;
        low_c     = (drop_c > ack_c) ? drop_c : ack_c + 1;
        rsp_c     = (rspd >= 0) ? rdly + rspd + 2 : -1;
        exp_rdata = resp_wins ? rdata : '0;
        exp_err   = resp_wins ? rerr : 1'b1;

        req_sync     = 1'b1;
        dmi_addr_in  = addr;
        dmi_wdata_in = wdata;
        dmi_wr_in    = wr;
        for (int c = 0; c <= low_c; c++) begin
            core_req_ready = (c == rdly + 1);
            core_rsp_valid = 1'b0;
            core_rsp_rdata = $urandom;
            core_rsp_err   = 1'($urandom_range(0, 1));
            if (c == rsp_c) begin
                core_rsp_valid = 1'b1;
                core_rsp_rdata = rdata;
                core_rsp_err   = rerr;
            end else if (c == 1 || c == ack_c + 1) begin
                // stray responses while in REQ or ACK must be ignored
                core_rsp_valid = 1'b1;
            end
            if (c >= drop_c) begin
                req_sync     = 1'b0;
                dmi_addr_in  = AW'($urandom);
                dmi_wdata_in = $urandom;
                dmi_wr_in    = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            tag       = $sformatf("%s c=%0d", name, c);
            exp_valid = (c <= rdly);
            exp_ack   = (c >= ack_c) && (c < low_c);
            checks++;
            if (core_req_valid !== exp_valid) begin
                failures++;
                $display("FAIL %s core_req_valid: got %b want %b", tag, core_req_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (core_req_addr !== addr || core_req_wdata !== wdata || core_req_wr !== wr) begin
                    failures++;
                    $display("FAIL %s payload: got %h/%h/%b want %h/%h/%b", tag, core_req_addr,
                             core_req_wdata, core_req_wr, addr, wdata, wr);
                end
            end
            checks++;
            if (ack_out !== exp_ack) begin
                failures++;
                $display("FAIL %s ack_out: got %b want %b", tag, ack_out, exp_ack);
            end
            if (exp_ack || c == low_c) begin
                checks++;
                if (rdata_out !== exp_rdata || err_out !== exp_err) begin
                    failures++;
                    $display("FAIL %s response: got rdata=%h err=%b want rdata=%h err=%b", tag,
                             rdata_out, err_out, exp_rdata, exp_err);
                end
            end
        end
        req_sync       = 1'b0;
        core_req_ready = 1'b0;
        core_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        req_sync       = 1'b0;
        dmi_addr_in    = '0;
        dmi_wdata_in   = '0;
        dmi_wr_in      = 1'b0;
        core_req_ready = 1'b0;
        core_rsp_valid = 1'b0;
        core_rsp_rdata = '0;
        core_rsp_err   = 1'b0;
        #2;
        checks++;
        if ({core_req_valid, core_req_addr, core_req_wdata, core_req_wr, ack_out, rdata_out,
             err_out} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got valid=%b addr=%h wdata=%h wr=%b ack=%b rdata=%h err=%b want all 0",
                     core_req_valid, core_req_addr, core_req_wdata, core_req_wr, ack_out,
                     rdata_out, err_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (core_req_valid !== 1'b0 || ack_out !== 1'b0) begin
                failures++;
                $display("FAIL reset idle: got valid=%b ack=%b want 0/0", core_req_valid, ack_out);
            end
        end
    endtask

    task automatic test_read();
        run_txn("read", 7'h11, 32'h0, 1'b0, 0, 3, 32'hDEADBEEF, 1'b0, 1'b0, 2);
    endtask

    task automatic test_write_backpressure();
        run_txn("write_bp", 7'h10, 32'h12345678, 1'b1, 5, 1, 32'h0, 1'b0, 1'b0, 1);
    endtask

    task automatic test_timeout();
        run_txn("timeout", 7'h22, 32'h0, 1'b0, 1, -1, 32'h0, 1'b0, 1'b0, 3);
        run_txn("timeout_late", 7'h23, 32'h0, 1'b0, 0, T + 1, 32'h13572468, 1'b0, 1'b0, 2);
    endtask

    task automatic test_simultaneous();
        run_txn("simult", 7'h30, 32'h0, 1'b0, 0, T, 32'hA5A5A5A5, 1'b0, 1'b0, 1);
    endtask

    task automatic test_early_drop();
        run_txn("early_drop", 7'h44, 32'h89ABCDEF, 1'b1, 2, 2, 32'h0BADF00D, 1'b1, 1'b1, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            run_txn($sformatf("rand%0d", i), AW'($urandom), $urandom, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 7)) - 1, $urandom,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    int'($urandom_range(1, 3)));
        end
    endtask

    task automatic test_reset_mid();
        req_sync       = 1'b1;
        dmi_addr_in    = 7'h55;
        dmi_wdata_in   = 32'hCAFEF00D;
        dmi_wr_in      = 1'b1;
        core_req_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        core_req_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (core_req_addr !== 7'h55) begin
            failures++;
            $display("FAIL reset_mid capture: got addr=%h want 55", core_req_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({core_req_valid, core_req_addr, core_req_wdata, core_req_wr, ack_out, rdata_out,
             err_out} !== '0) begin
            failures++;
            $display("FAIL reset_mid async clear: got valid=%b addr=%h wdata=%h wr=%b ack=%b rdata=%h err=%b want all 0",
                     core_req_valid, core_req_addr, core_req_wdata, core_req_wr, ack_out,
                     rdata_out, err_out);
        end
        req_sync = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            core_rsp_valid = (c == 1);
            core_rsp_rdata = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (ack_out !== 1'b0 || core_req_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid idle c=%0d: got ack=%b valid=%b want 0/0", c, ack_out,
                         core_req_valid);
            end
        end
        core_rsp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_backpressure();
        test_timeout();
        test_simultaneous();
        test_early_drop();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
